// File: rtl/sdr_pkg.sv
// sdr_pkg: shared definitions for the sample deframer.
//   - frame marker / type codes and config reset values
//   - FSM state encoding
//   - config register bundle and its reset value
package sdr_pkg;

    localparam logic [7:0] SDR_SYNC_BYTE         = 8'hA5;
    localparam logic [7:0] SDR_TYPE_SAMPLES      = 8'h01;
    localparam logic [7:0] SDR_TYPE_CONFIG       = 8'h02;
    localparam logic [7:0] SDR_CFG_CLKS_DEFAULT  = 8'd1;
    localparam logic [7:0] SDR_CFG_STEPS_DEFAULT = 8'd63;

    // Config payload is exactly four bytes:
    // clks_per_step, steps_per_sample, mod_sel[1:0], enable[0]
    localparam logic [7:0] SDR_CFG_LEN = 8'd4;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_TYPE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } sdr_state_t;

    typedef struct packed {
        logic [7:0] clks_per_step;
        logic [7:0] steps_per_sample;
        logic [1:0] mod_sel;
        logic       enable;
    } sdr_cfg_t;

    function automatic sdr_cfg_t sdr_cfg_reset(input logic [7:0] clks,
                                               input logic [7:0] steps);
        sdr_cfg_t c;
        c.clks_per_step    = clks;
        c.steps_per_sample = steps;
        c.mod_sel          = 2'd0;
        c.enable           = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk, rst  clock, async active-high reset (count -> 0)
//   inc       count up by one this cycle
//   count     current value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sample_deframer.sv
// sample_deframer: parses the host byte stream coming out of the FT245 RX
// path. Frame = SYNC, TYPE, LEN, LEN payload bytes, CHK, where CHK is the
// XOR of TYPE, LEN and all payload bytes.
//   - sample frames: each payload byte goes to the sample FIFO one cycle
//     after it is accepted (forwarded before CHK is known, never retracted)
//   - config frames: four payload bytes land in shadow registers and are
//     copied to cfg_* only when the frame checks out
//   - good/bad frame counts saturate at all-ones
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_data/in_valid/in_ready byte stream from the FT245 interface
//   out_data/out_valid        FIFO write data / write enable
//   out_ready                 FIFO not full
//   cfg_*                     modulator configuration
//   frame_ok_cnt/_err_cnt     debug frame counters
module sample_deframer
    import sdr_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE         = SDR_SYNC_BYTE,
    parameter logic [7:0] TYPE_SAMPLES      = SDR_TYPE_SAMPLES,
    parameter logic [7:0] TYPE_CONFIG       = SDR_TYPE_CONFIG,
    parameter logic [7:0] CFG_CLKS_DEFAULT  = SDR_CFG_CLKS_DEFAULT,
    parameter logic [7:0] CFG_STEPS_DEFAULT = SDR_CFG_STEPS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  cfg_clks_per_step,
    output logic [7:0]  cfg_steps_per_sample,
    output logic [1:0]  cfg_mod_sel,
    output logic        cfg_enable,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_err_cnt
);

    sdr_state_t state, state_nxt;

    logic [7:0] ftype;   // type byte of the frame in progress
    logic [7:0] len;     // declared payload length
    logic [7:0] remain;  // payload bytes still to come
    logic [7:0] csum;    // running XOR
    logic [7:0] pay_idx; // index of the current payload byte
    sdr_cfg_t   shadow;
    sdr_cfg_t   cfg;

    logic accept;
    logic is_sample;
    logic chk_good;
    logic ok_inc;
    logic err_inc;
    logic cfg_load;

    assign accept    = in_valid & in_ready;
    assign is_sample = (ftype == TYPE_SAMPLES);
    assign chk_good  = (in_data == csum);
    assign pay_idx   = len - remain;

    // ------------------------------------------------------------------
    // Backpressure: only sample payload bytes need a free output slot,
    // but the gate is applied to every payload byte so the handshake
    // does not depend on the frame type.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b1;
        if (state == ST_PAYLOAD) begin
            in_ready = !out_valid || out_ready;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ok_inc    = 1'b0;
        err_inc   = 1'b0;
        cfg_load  = 1'b0;
        if (accept) begin
            unique case (state)
                ST_HUNT: begin
                    if (in_data == SYNC_BYTE) begin
                        state_nxt = ST_TYPE;
                    end
                end
                ST_TYPE: begin
                    state_nxt = ST_LEN;
                end
                ST_LEN: begin
                    state_nxt = (in_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (remain == 8'd1) begin
                        state_nxt = ST_CHK;
                    end
                end
                ST_CHK: begin
                    state_nxt = ST_HUNT;
                    if (ftype == TYPE_SAMPLES) begin
                        ok_inc  = chk_good;
                        err_inc = !chk_good;
                    end else if (ftype == TYPE_CONFIG) begin
                        if (chk_good && (len == SDR_CFG_LEN)) begin
                            ok_inc   = 1'b1;
                            cfg_load = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else begin
                        // Unknown type: always counted as bad, CHK ignored.
                        err_inc = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame header / checksum datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ftype  <= 8'd0;
            len    <= 8'd0;
            remain <= 8'd0;
            csum   <= 8'd0;
        end else if (accept) begin
            unique case (state)
                ST_TYPE: begin
                    ftype <= in_data;
                    csum  <= in_data;
                end
                ST_LEN: begin
                    len    <= in_data;
                    remain <= in_data;
                    csum   <= csum ^ in_data;
                end
                ST_PAYLOAD: begin
                    remain <= remain - 8'd1;
                    csum   <= csum ^ in_data;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Config shadow and live registers. Bytes past the fourth of an
    // over-long config frame are ignored; such a frame is never applied.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= sdr_cfg_reset(CFG_CLKS_DEFAULT, CFG_STEPS_DEFAULT);
        end else if (accept && (state == ST_PAYLOAD) && (ftype == TYPE_CONFIG)) begin
            unique case (pay_idx)
                8'd0:    shadow.clks_per_step    <= in_data;
                8'd1:    shadow.steps_per_sample <= in_data;
                8'd2:    shadow.mod_sel          <= in_data[1:0];
                8'd3:    shadow.enable           <= in_data[0];
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg <= sdr_cfg_reset(CFG_CLKS_DEFAULT, CFG_STEPS_DEFAULT);
        end else if (cfg_load) begin
            cfg <= shadow;
        end
    end

    assign cfg_clks_per_step    = cfg.clks_per_step;
    assign cfg_steps_per_sample = cfg.steps_per_sample;
    assign cfg_mod_sel          = cfg.mod_sel;
    assign cfg_enable           = cfg.enable;

    // ------------------------------------------------------------------
    // Output register. A new byte can only be accepted when the slot is
    // empty or draining this cycle, so the load never overwrites a byte
    // the FIFO has not taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= 8'd0;
            out_valid <= 1'b0;
        end else if (accept && (state == ST_PAYLOAD) && is_sample) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame counters
    // ------------------------------------------------------------------
    sat_counter #(.WIDTH(16)) u_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ok_inc),
        .count (frame_ok_cnt)
    );

    sat_counter #(.WIDTH(16)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .count (frame_err_cnt)
    );

endmodule

// File: tb/tb_sample_deframer.sv
module tb_sample_deframer;
    import sdr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  cfg_clks_per_step;
    logic [7:0]  cfg_steps_per_sample;
    logic [1:0]  cfg_mod_sel;
    logic        cfg_enable;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;

    logic [7:0] exp_q[$];  // scoreboard: sample bytes the FIFO must see
    logic [7:0] pbuf[$];   // payload of the next frame to send

    always #5 clk = ~clk;

    sample_deframer dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .out_data             (out_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .cfg_clks_per_step    (cfg_clks_per_step),
        .cfg_steps_per_sample (cfg_steps_per_sample),
        .cfg_mod_sel          (cfg_mod_sel),
        .cfg_enable           (cfg_enable),
        .frame_ok_cnt         (frame_ok_cnt),
        .frame_err_cnt        (frame_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO-side monitor: a write happens at the next posedge when both
    // valid and ready are high; sampled late in the low phase.
    always @(negedge clk) begin
        #3;
        if (!rst && out_valid && out_ready) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 32'(out_valid), 32'd0);
            end else begin
                chk("fifo_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input bit is_sample);
        bit done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else if (is_sample) begin
            chk("lat_valid", 32'(out_valid), 32'd1);
            chk("lat_data", 32'(out_data), 32'(b));
        end
    endtask

    task automatic send_frame(input logic [7:0] t, input logic [7:0] len,
                              input logic [7:0] chk_flip);
        logic [7:0] c;
        c = t ^ len;
        foreach (pbuf[i]) c = c ^ pbuf[i];
        send_byte(SDR_SYNC_BYTE, 1'b0);
        send_byte(t, 1'b0);
        send_byte(len, 1'b0);
        foreach (pbuf[i]) begin
            if (t == SDR_TYPE_SAMPLES) exp_q.push_back(pbuf[i]);
            send_byte(pbuf[i], t == SDR_TYPE_SAMPLES);
        end
        send_byte(c ^ chk_flip, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int writes_before, input int n_exp);
        repeat (3) @(negedge clk);
        chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_writes"}, 32'(n_writes - writes_before), 32'(n_exp));
    endtask

    task automatic check_cfg(input string tag, input logic [7:0] c, input logic [7:0] s,
                             input logic [1:0] m, input logic e);
        chk({tag, "_clks"}, 32'(cfg_clks_per_step), 32'(c));
        chk({tag, "_steps"}, 32'(cfg_steps_per_sample), 32'(s));
        chk({tag, "_mod"}, 32'(cfg_mod_sel), 32'(m));
        chk({tag, "_en"}, 32'(cfg_enable), 32'(e));
    endtask

    task automatic check_cnt(input string tag, input int ok, input int err);
        chk({tag, "_ok"}, 32'(frame_ok_cnt), 32'(ok));
        chk({tag, "_err"}, 32'(frame_err_cnt), 32'(err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        check_cfg("rst", 8'd1, 8'd63, 2'd0, 1'b0);
        check_cnt("rst", 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Sample frame, no backpressure
        w0 = n_writes;
        pbuf = '{8'h10, 8'h20, 8'h30};
        send_frame(SDR_TYPE_SAMPLES, 8'd3, 8'h00);
        drain("smp", w0, 3);
        check_cnt("smp", 1, 0);

        // Good config frame
        do_reset();
        w0 = n_writes;
        pbuf = '{8'h02, 8'h3F, 8'h01, 8'h01};
        send_frame(SDR_TYPE_CONFIG, 8'd4, 8'h00);
        check_cfg("cfg_good", 8'd2, 8'd63, 2'd1, 1'b1);
        drain("cfg_good", w0, 0);
        check_cnt("cfg_good", 1, 0);

        // Same config frame, CHK=3C instead of 3B
        do_reset();
        w0 = n_writes;
        send_frame(SDR_TYPE_CONFIG, 8'd4, 8'h07);
        check_cfg("cfg_bad", 8'd1, 8'd63, 2'd0, 1'b0);
        drain("cfg_bad", w0, 0);
        check_cnt("cfg_bad", 0, 1);

        // Leading garbage is discarded in HUNT
        do_reset();
        w0 = n_writes;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h12, 1'b0);
        pbuf = '{8'hAA};
        send_frame(SDR_TYPE_SAMPLES, 8'd1, 8'h00);
        drain("garbage", w0, 1);
        check_cnt("garbage", 1, 0);

        // FIFO full for 5 cycles after the first sample byte
        do_reset();
        w0 = n_writes;
        pbuf = '{8'h10, 8'h20, 8'h30};
        fork
            send_frame(SDR_TYPE_SAMPLES, 8'd3, 8'h00);
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                end
                chk("stall_seen", 32'(seen), 32'd1);
                out_ready = 1'b0;
                repeat (5) begin
                    #1;
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_hold_v", 32'(out_valid), 32'd1);
                    chk("stall_hold_d", 32'(out_data), 32'h10);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain("stall", w0, 3);
        check_cnt("stall", 1, 0);

        // Reset in the middle of a sample frame
        do_reset();
        send_byte(SDR_SYNC_BYTE, 1'b0);
        send_byte(SDR_TYPE_SAMPLES, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h10, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        w0 = n_writes;
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h02, 1'b0);
        drain("midrst_tail", w0, 0);
        check_cnt("midrst_tail", 0, 0);
        w0 = n_writes;
        pbuf = '{8'hAA};
        send_frame(SDR_TYPE_SAMPLES, 8'd1, 8'h00);
        drain("midrst_next", w0, 1);
        check_cnt("midrst_next", 1, 0);

        // Zero-length sample frame
        w0 = n_writes;
        pbuf.delete();
        send_frame(SDR_TYPE_SAMPLES, 8'd0, 8'h00);
        drain("len0", w0, 0);
        check_cnt("len0", 2, 0);

        // SYNC value inside payload is plain data
        w0 = n_writes;
        pbuf = '{SDR_SYNC_BYTE, SDR_SYNC_BYTE};
        send_frame(SDR_TYPE_SAMPLES, 8'd2, 8'h00);
        drain("sync_data", w0, 2);
        check_cnt("sync_data", 3, 0);

        // Config frame with wrong length but correct CHK
        pbuf = '{8'h09, 8'h09, 8'h03};
        send_frame(SDR_TYPE_CONFIG, 8'd3, 8'h00);
        check_cfg("cfg_len3", 8'd1, 8'd63, 2'd0, 1'b0);
        check_cnt("cfg_len3", 3, 1);

        // Unknown type with correct CHK
        w0 = n_writes;
        pbuf = '{8'h55};
        send_frame(8'h07, 8'd1, 8'h00);
        drain("unknown", w0, 0);
        check_cnt("unknown", 3, 2);

        // Config fields take only their defined bits
        pbuf = '{8'h05, 8'h10, 8'hFF, 8'hFE};
        send_frame(SDR_TYPE_CONFIG, 8'd4, 8'h00);
        check_cfg("cfg_mask", 8'd5, 8'h10, 2'd3, 1'b0);
        check_cnt("cfg_mask", 4, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
